// File: rtl/seq_mult_datapath.sv
// Operand capture and W-cycle shift-add multiplier datapath.
// Shows the entered operand or the product on NDIG hex 7-segment digits.
module seq_mult_datapath #(
    parameter int unsigned W        = 8,
    parameter int unsigned NDIG     = 4,
    parameter bit          SEG_ALOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enter,
    input  logic [W-1:0]          inputdata,
    input  logic                  loaddata,
    output logic                  inputdata_ready,
    output logic                  busy,
    output logic                  done,
    output logic [2*W-1:0]        product,
    output logic [NDIG*7-1:0]     disp
);

    localparam int unsigned CW = $clog2(W);
    localparam int unsigned PW = 2 * W;
    localparam int unsigned DW = NDIG * 4;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, MUL, DONE} state_t;

    state_t          state, state_d;
    logic [W-1:0]    a, a_d, b, b_d;
    logic [PW-1:0]   acc, acc_d, product_d;
    logic [PW-1:0]   partial, sum;
    logic [CW-1:0]   cnt, cnt_d;
    logic            enter_q;
    logic            press, cap;
    logic [DW-1:0]   disp_val;

    // Next-state and datapath update
    always_comb begin
        state_d   = state;
        a_d       = a;
        b_d       = b;
        acc_d     = acc;
        cnt_d     = cnt;
        product_d = product;
        press     = enter & ~enter_q;
        cap       = press & loaddata;
        partial   = b[cnt] ? (PW'(a) << cnt) : '0;
        sum       = acc + partial;
        case (state)
            LOAD_A: begin
                if (cap) begin
                    a_d     = inputdata;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (cap) begin
                    b_d     = inputdata;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d = sum;
                if (cnt == CW'(W - 1)) begin
                    product_d = sum;
                    state_d   = DONE;
                end else begin
                    cnt_d = CW'(cnt + 1'b1);
                end
            end
            DONE: begin
                if (press) state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LOAD_A;
            a       <= '0;
            b       <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            enter_q <= 1'b0;
        end else begin
            state   <= state_d;
            a       <= a_d;
            b       <= b_d;
            acc     <= acc_d;
            cnt     <= cnt_d;
            product <= product_d;
            enter_q <= enter;
        end
    end

    assign inputdata_ready = (state == LOAD_A) || (state == LOAD_B);
    assign busy            = (state == MUL);
    assign done            = (state == DONE);

    // Live switch value while loading, product otherwise
    assign disp_val = inputdata_ready ? DW'(inputdata) : DW'(product);

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'b1000000;
            4'h1: code = 7'b1111001;
            4'h2: code = 7'b0100100;
            4'h3: code = 7'b0110000;
            4'h4: code = 7'b0011001;
            4'h5: code = 7'b0010010;
            4'h6: code = 7'b0000010;
            4'h7: code = 7'b1111000;
            4'h8: code = 7'b0000000;
            4'h9: code = 7'b0010000;
            4'hA: code = 7'b0001000;
            4'hB: code = 7'b0000011;
            4'hC: code = 7'b1000110;
            4'hD: code = 7'b0100001;
            4'hE: code = 7'b0000110;
            default: code = 7'b0001110;
        endcase
        return SEG_ALOW ? code : ~code;
    endfunction

    for (genvar k = 0; k < int'(NDIG); k++) begin : g_dig
        assign disp[7*k +: 7] = seg7(disp_val[4*k +: 4]);
    end

endmodule

// File: tb/tb_seq_mult_datapath.sv
// Directed self-checking bench for seq_mult_datapath (W=8/NDIG=4 and W=4/NDIG=2).
module tb_seq_mult_datapath;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enter = 1'b0;
    logic [7:0]  inputdata = '0;
    logic        loaddata = 1'b0;
    logic        inputdata_ready, busy, done;
    logic [15:0] product;
    logic [27:0] disp;

    logic        enter4 = 1'b0;
    logic [3:0]  inputdata4 = '0;
    logic        loaddata4 = 1'b0;
    logic        ready4, busy4, done4;
    logic [7:0]  product4;
    logic [13:0] disp4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_mult_datapath #(.W(8), .NDIG(4), .SEG_ALOW(1'b1)) u_dut (
        .clk(clk), .reset(reset), .enter(enter), .inputdata(inputdata),
        .loaddata(loaddata), .inputdata_ready(inputdata_ready), .busy(busy),
        .done(done), .product(product), .disp(disp)
    );

    seq_mult_datapath #(.W(4), .NDIG(2), .SEG_ALOW(1'b1)) u_dut4 (
        .clk(clk), .reset(reset), .enter(enter4), .inputdata(inputdata4),
        .loaddata(loaddata4), .inputdata_ready(ready4), .busy(busy4),
        .done(done4), .product(product4), .disp(disp4)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        logic [27:0] segs;
    } vec_t;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SF = 7'b0001110;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One-cycle enter pulse followed by a release cycle
    task automatic press(input logic [7:0] d, input logic ld);
        inputdata = d;
        loaddata  = ld;
        enter     = 1'b1;
        tick();
        enter     = 1'b0;
        tick();
    endtask

    // Load A and B, then count busy cycles; optionally toggle enter during MUL
    task automatic run_mult(input logic [7:0] a, input logic [7:0] b,
                            input bit noisy, output int cycles);
        press(a, 1'b1);
        inputdata = b;
        loaddata  = 1'b1;
        enter     = 1'b1;
        tick();
        enter  = 1'b0;
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            if (noisy) enter = ~enter;
            tick();
        end
        enter = 1'b0;
    endtask

    int cyc;

    initial begin
        vecs[0] = '{8'd12,  8'd13,  16'h009C, {S0, S0, S9, SC}};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01, {SF, SE, S0, S1}};
        vecs[2] = '{8'd0,   8'd200, 16'h0000, {S0, S0, S0, S0}};
        vecs[3] = '{8'd128, 8'd2,   16'h0100, {S0, S1, S0, S0}};
        vecs[4] = '{8'd1,   8'd1,   16'h0001, {S0, S0, S0, S1}};

        // Reset held two cycles
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", 64'(inputdata_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_disp", 64'(disp), 64'({S0, S0, S0, S0}));
        inputdata = 8'hC9;
        #1;
        chk("load_disp_live", 64'(disp), 64'({S0, S0, SC, S9}));

        // Table-driven multiplies
        foreach (vecs[i]) begin
            run_mult(vecs[i].a, vecs[i].b, 1'b0, cyc);
            chk($sformatf("v%0d_cycles", i), 64'(cyc), 64'd8);
            chk($sformatf("v%0d_done", i), 64'(done), 64'd1);
            chk($sformatf("v%0d_product", i), 64'(product), 64'(vecs[i].prod));
            chk($sformatf("v%0d_disp", i), 64'(disp), 64'(vecs[i].segs));
            press(8'h00, 1'b0);
            chk($sformatf("v%0d_back_ready", i), 64'(inputdata_ready), 64'd1);
        end

        // Held enter captures A once; loaddata=0 press ignored
        inputdata = 8'h11;
        loaddata  = 1'b1;
        enter     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) inputdata = 8'h44;
            tick();
        end
        enter = 1'b0;
        tick();
        chk("held_busy", 64'(busy), 64'd0);
        chk("held_ready", 64'(inputdata_ready), 64'd1);
        press(8'h07, 1'b0);
        chk("noload_busy", 64'(busy), 64'd0);
        inputdata = 8'h03;
        loaddata  = 1'b1;
        enter     = 1'b1;
        tick();
        enter = 1'b0;
        chk("held_mul_start", 64'(busy), 64'd1);
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            tick();
        end
        chk("held_product", 64'(product), 64'h0033);
        press(8'h00, 1'b1);

        // Presses during MUL are ignored
        run_mult(8'd12, 8'd13, 1'b1, cyc);
        chk("noisy_cycles", 64'(cyc), 64'd8);
        chk("noisy_product", 64'(product), 64'h009C);
        tick();
        chk("done_holds", 64'(done), 64'd1);
        press(8'h00, 1'b0);
        chk("done_press_ready", 64'(inputdata_ready), 64'd1);
        chk("done_press_done", 64'(done), 64'd0);

        // Reset on the third MUL cycle aborts
        press(8'd12, 1'b1);
        inputdata = 8'd13;
        enter     = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        tick();
        chk("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(inputdata_ready), 64'd1);
        chk("abort_product", 64'(product), 64'd0);
        run_mult(8'd3, 8'd5, 1'b0, cyc);
        chk("after_abort_cycles", 64'(cyc), 64'd8);
        chk("after_abort_product", 64'(product), 64'd15);

        // W=4 instance: 15*15
        inputdata4 = 4'hF;
        loaddata4  = 1'b1;
        enter4     = 1'b1;
        tick();
        enter4 = 1'b0;
        tick();
        enter4 = 1'b1;
        tick();
        enter4 = 1'b0;
        cyc = 0;
        while (busy4 && cyc < 40) begin
            cyc++;
            tick();
        end
        chk("w4_cycles", 64'(cyc), 64'd4);
        chk("w4_done", 64'(done4), 64'd1);
        chk("w4_product", 64'(product4), 64'hE1);
        chk("w4_disp", 64'(disp4), 64'({SE, S1}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
